ps2_rx_fifo: RTL and testbench

PS/2 device-to-host receiver with configurable clock deglitch filter, full frame checking, a mid-frame watchdog and an output byte FIFO.
- Frame checks: start, odd parity, stop.
- Sits between the PS/2 pins and keyboard/mouse decode logic.
- Lets the consumer drain scan codes at its own pace. Bad frames are discarded and reported, never delivered.

---
 rtl/ps2_rx_fifo.sv | 189 ++++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver with
// clock deglitch, frame checks, watchdog and byte FIFO.
module ps2_rx_fifo #(
   parameter int FILTER_LEN     = 8,
   parameter int FIFO_DEPTH     = 8,
   parameter int TIMEOUT_CYCLES = 50000,
   parameter bit CHECK_PARITY   = 1'b1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        ps2_clk,
   input  logic                        ps2_data,
   input  logic                        rx_en,
   input  logic                        rd_en,
   input  logic                        err_clr,
   output logic [7:0]                  dout,
   output logic                        empty,
   output logic                        full,
   output logic [$clog2(FIFO_DEPTH):0] count,
   output logic                        rx_done_tick,
   output logic                        parity_err,
   output logic                        frame_err,
   output logic                        overflow
);

   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int CW  = AW + 1;
   localparam int WDW = $clog2(TIMEOUT_CYCLES);
   localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0]  DEPTH   = CW'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      IDLE, DATA, PAR, STOP, PUSH
   } state_t;

   state_t state, state_n;

   logic [1:0]            clk_sync;
   logic [1:0]            data_sync;
   logic [FILTER_LEN-1:0] filt;
   logic                  f_clk, f_clk_n;
   logic                  fall_edge, din;
   logic [7:0]            shreg;
   logic                  par;
   logic [2:0]            bit_idx;
   logic [WDW-1:0]        wd;
   logic                  in_frame, wd_expired;
   logic                  set_ferr, set_perr, push;
   logic                  do_wr, do_rd;
   logic [7:0]            mem [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr, rd_ptr;

   assign f_clk_n = (&filt)  ? 1'b1 :
                    (~|filt) ? 1'b0 : f_clk;
   assign fall_edge = f_clk & ~f_clk_n;
   assign din       = data_sync[1];

   // Synchronizers and clock filter; the clock chain idles
   // high like the pin so leaving reset cannot fake an edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_sync  <= 2'b11;
         data_sync <= 2'b00;
         filt      <= '1;
         f_clk     <= 1'b1;
      end else begin
         clk_sync  <= {clk_sync[0], ps2_clk};
         data_sync <= {data_sync[0], ps2_data};
         filt      <= {filt[FILTER_LEN-2:0], clk_sync[1]};
         f_clk     <= f_clk_n;
      end
   end

   assign in_frame   = (state == DATA) || (state == PAR) ||
                       (state == STOP);
   assign wd_expired = in_frame && !fall_edge && (wd == WD_LAST);

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   // FSM next state and frame verdicts
   always_comb begin
      state_n  = state;
      set_ferr = 1'b0;
      set_perr = 1'b0;
      push     = 1'b0;
      unique case (state)
         IDLE: begin
            if (fall_edge && rx_en) begin
               if (!din) state_n = DATA;
               else      set_ferr = 1'b1;
            end
         end
         DATA: begin
            if (fall_edge && bit_idx == 3'd7) state_n = PAR;
         end
         PAR: begin
            if (fall_edge) state_n = STOP;
         end
         STOP: begin
            if (fall_edge) begin
               state_n = IDLE;
               if (!din)
                  set_ferr = 1'b1;
               else if (CHECK_PARITY && !(^{shreg, par}))
                  set_perr = 1'b1;
               else
                  state_n = PUSH;
            end
         end
         PUSH: begin
            push    = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      if (wd_expired) begin
         state_n  = IDLE;
         set_ferr = 1'b1;
      end
   end

   // Frame shift register, bit counter, parity and watchdog
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shreg   <= '0;
         par     <= 1'b0;
         bit_idx <= '0;
         wd      <= '0;
      end else begin
         if (fall_edge || !in_frame) wd <= '0;
         else                        wd <= wd + 1'b1;
         if (state == IDLE) begin
            bit_idx <= '0;
         end else if (state == DATA && fall_edge) begin
            shreg   <= {din, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
         end
         if (state == PAR && fall_edge) par <= din;
      end
   end

   assign empty        = (count == '0);
   assign full         = (count == DEPTH);
   assign do_rd        = rd_en & ~empty;
   assign do_wr        = push & (~full | rd_en);
   assign rx_done_tick = do_wr;
   assign dout         = empty ? 8'h00 : mem[rd_ptr];

   // FIFO storage; contents are masked by empty
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= shreg;
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         unique case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Sticky error flags; a new error wins over err_clr
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         parity_err <= (parity_err & ~err_clr) | set_perr;
         frame_err  <= (frame_err & ~err_clr) | set_ferr;
         overflow   <= (overflow & ~err_clr) |
                       (push & full & ~rd_en);
      end
   end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: directed frames against a queue model
// of the receiver FIFO and its sticky error flags.
module tb_ps2_rx_fifo;

   localparam int L    = 8;
   localparam int T    = 100;
   localparam int HALF = 12;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic ps2_clk = 1'b1, ps2_data = 1'b1;
   logic rx_en = 1'b0, rd_en = 1'b0, err_clr = 1'b0;

   logic [7:0] dout, dout_b;
   logic       empty, full, tick, perr, ferr, ovf;
   logic       empty_b, full_b, tick_b, perr_b, ferr_b, ovf_b;
   logic [3:0] count, count_b;

   int n_checks = 0;
   int n_fail   = 0;
   int ticks    = 0;
   bit chk_on   = 1'b0;

   logic [7:0] mq[$];
   logic       m_perr = 1'b0, m_ferr = 1'b0;
   logic       m_ovf = 1'b0, m_tick = 1'b0;

   ps2_rx_fifo #(
      .FILTER_LEN(L), .FIFO_DEPTH(8),
      .TIMEOUT_CYCLES(T), .CHECK_PARITY(1'b1)
   ) dut (
      .clk(clk), .reset(reset),
      .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .rx_en(rx_en), .rd_en(rd_en), .err_clr(err_clr),
      .dout(dout), .empty(empty), .full(full),
      .count(count), .rx_done_tick(tick),
      .parity_err(perr), .frame_err(ferr),
      .overflow(ovf)
   );

   ps2_rx_fifo #(
      .FILTER_LEN(L), .FIFO_DEPTH(8),
      .TIMEOUT_CYCLES(T), .CHECK_PARITY(1'b0)
   ) dut_np (
      .clk(clk), .reset(reset),
      .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .rx_en(rx_en), .rd_en(rd_en), .err_clr(err_clr),
      .dout(dout_b), .empty(empty_b), .full(full_b),
      .count(count_b), .rx_done_tick(tick_b),
      .parity_err(perr_b), .frame_err(ferr_b),
      .overflow(ovf_b)
   );

   always #5 clk = ~clk;

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h",
                  name, act, exp);
      end
   endtask

   function automatic logic odd_par(input logic [7:0] d);
      return ~^d;
   endfunction

   // per-cycle comparison against the model
   always @(posedge clk) begin
      logic [7:0] e_dout;
      #2;
      if (chk_on) begin
         e_dout = (mq.size() > 0) ? mq[0] : 8'h00;
         check("dout", 32'(dout), 32'(e_dout));
         check("count", 32'(count), 32'(mq.size()));
         check("empty", 32'(empty), 32'(mq.size() == 0));
         check("full", 32'(full), 32'(mq.size() == 8));
         check("tick", 32'(tick), 32'(m_tick));
         check("parity_err", 32'(perr), 32'(m_perr));
         check("frame_err", 32'(ferr), 32'(m_ferr));
         check("overflow", 32'(ovf), 32'(m_ovf));
      end
   end

   always @(posedge clk) begin
      if (!reset && tick) ticks++;
   end

   initial begin
      repeat (60000) @(posedge clk);
      $display("FAIL timeout: actual running required done");
      $fatal(1, "cycle budget exhausted");
   end

   task automatic send_bit(input logic b);
      @(negedge clk) ps2_data = b;
      repeat (HALF - 1) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] d,
                             input logic par,
                             input logic stop,
                             input bit rd = 1'b0,
                             input bit clr = 1'b0);
      bit good;
      good = 1'b0;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(par);
      @(negedge clk) ps2_data = stop;
      repeat (HALF - 1) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (L + 2) @(posedge clk);
      #1 err_clr = clr;
      @(posedge clk);
      #1 err_clr = 1'b0;
      if (clr) {m_perr, m_ferr, m_ovf} = 3'b000;
      if (rx_en) begin
         if (!stop) m_ferr = 1'b1;
         else if (!(^{d, par})) m_perr = 1'b1;
         else begin
            good   = 1'b1;
            m_tick = (mq.size() < 8) || rd;
         end
      end
      rd_en = rd;
      @(posedge clk);
      #1 m_tick = 1'b0;
      rd_en = 1'b0;
      if (rd && mq.size() > 0) void'(mq.pop_front());
      if (good) begin
         if (mq.size() < 8) mq.push_back(d);
         else               m_ovf = 1'b1;
      end
      @(negedge clk) ps2_clk = 1'b1;
      ps2_data = 1'b1;
      repeat (2 * HALF) @(negedge clk);
   endtask

   task automatic good_frame(input logic [7:0] d,
                             input bit rd = 1'b0);
      send_frame(d, odd_par(d), 1'b1, rd);
   endtask

   task automatic read_one(output logic [7:0] v);
      @(negedge clk) v = dout;
      rd_en = 1'b1;
      @(posedge clk);
      #1 rd_en = 1'b0;
      if (mq.size() > 0) void'(mq.pop_front());
   endtask

   task automatic clear_err();
      @(negedge clk) err_clr = 1'b1;
      @(posedge clk);
      #1 err_clr = 1'b0;
      {m_perr, m_ferr, m_ovf} = 3'b000;
   endtask

   initial begin
      logic [7:0] v;
      logic [7:0] wdat;
      int t0;

      repeat (3) @(negedge clk);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_dout", 32'(dout), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_full", 32'(full), 32'd0);
      check("rst_tick", 32'(tick), 32'd0);
      check("rst_flags", 32'({perr, ferr, ovf}), 32'd0);
      reset  = 1'b0;
      chk_on = 1'b1;
      rx_en  = 1'b1;
      repeat (HALF) @(negedge clk);

      // good frame 0x1C
      send_frame(8'h1C, 1'b0, 1'b1);
      @(negedge clk);
      check("t1_dout", 32'(dout), 32'h1C);
      check("t1_count", 32'(count), 32'd1);
      check("t1_ticks", 32'(ticks), 32'd1);
      read_one(v);
      check("t1_read", 32'(v), 32'h1C);
      @(negedge clk);
      check("t1_empty", 32'(empty), 32'd1);
      check("t1_dout0", 32'(dout), 32'd0);

      // bad parity, dropped here, kept by the no-check unit
      send_frame(8'h1C, 1'b1, 1'b1);
      check("t2_perr", 32'(perr), 32'd1);
      check("t2_empty", 32'(empty), 32'd1);
      check("t2_np_count", 32'(count_b), 32'd1);
      check("t2_np_dout", 32'(dout_b), 32'h1C);
      check("t2_np_perr", 32'(perr_b), 32'd0);
      send_frame(8'h1C, 1'b1, 1'b1, 1'b0, 1'b1);
      check("t2_clr_race", 32'(perr), 32'd1);
      clear_err();
      @(negedge clk);
      check("t2_cleared", 32'(perr), 32'd0);

      // framing error then a good frame
      send_frame(8'hF0, odd_par(8'hF0), 1'b0);
      check("t3_ferr", 32'(ferr), 32'd1);
      check("t3_empty", 32'(empty), 32'd1);
      good_frame(8'hAA);
      read_one(v);
      check("t3_read", 32'(v), 32'hAA);
      clear_err();

      // overflow with nine frames
      t0 = ticks;
      for (int i = 1; i <= 9; i++) good_frame(8'(i));
      check("t4_count", 32'(count), 32'd8);
      check("t4_full", 32'(full), 32'd1);
      check("t4_ovf", 32'(ovf), 32'd1);
      check("t4_ticks", 32'(ticks - t0), 32'd8);
      read_one(v);
      check("t4_read1", 32'(v), 32'h01);
      clear_err();
      good_frame(8'h0A);
      good_frame(8'h0B, 1'b1);
      check("t6_wr_rd_count", 32'(count), 32'd8);
      check("t6_wr_rd_ovf", 32'(ovf), 32'd0);
      for (int i = 3; i <= 8; i++) begin
         read_one(v);
         check("t4_order", 32'(v), 32'(i));
      end
      read_one(v);
      check("t4_read_a", 32'(v), 32'h0A);
      read_one(v);
      check("t4_read_b", 32'(v), 32'h0B);
      read_one(v);
      @(negedge clk);
      check("t4_rd_empty", 32'(count), 32'd0);

      // watchdog: start plus four bits, then silence
      wdat = 8'h5A;
      send_bit(1'b0);
      for (int i = 0; i < 3; i++) send_bit(wdat[i]);
      @(negedge clk) ps2_data = wdat[3];
      repeat (HALF - 1) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      repeat (L + T - 10) @(posedge clk);
      #1 check("t5_before", 32'(ferr), 32'd0);
      @(posedge clk);
      #1 m_ferr = 1'b1;
      check("t5_at", 32'(ferr), 32'd1);
      repeat (HALF) @(negedge clk);
      good_frame(8'h5A);
      read_one(v);
      check("t5_read", 32'(v), 32'h5A);
      clear_err();

      // short clock glitches never count as edges
      for (int d = 0; d < 2; d++) begin
         @(negedge clk) ps2_data = 1'(d);
         for (int i = 0; i < 4; i++) begin
            @(negedge clk) ps2_clk = 1'b0;
            repeat (L - 2) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (HALF) @(negedge clk);
         end
         repeat (T + 20) @(negedge clk);
         check("t6_glitch", 32'({ferr, empty}), 32'b01);
      end
      ps2_data = 1'b1;

      // receiver disabled
      t0 = ticks;
      rx_en = 1'b0;
      good_frame(8'h33);
      check("t6_rxen_ticks", 32'(ticks - t0), 32'd0);
      check("t6_rxen_state", 32'({empty, ferr, perr}), 32'b100);
      rx_en = 1'b1;

      // reset with a byte stored and a frame in flight
      good_frame(8'h77);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      @(negedge clk) reset = 1'b1;
      mq.delete();
      {m_perr, m_ferr, m_ovf, m_tick} = 4'b0000;
      #1 check("t7_rst_empty", 32'(empty), 32'd1);
      check("t7_rst_count", 32'(count), 32'd0);
      repeat (2) @(negedge clk);
      reset    = 1'b0;
      ps2_data = 1'b1;
      repeat (HALF) @(negedge clk);
      good_frame(8'h3C);
      read_one(v);
      check("t7_read", 32'(v), 32'h3C);

      repeat (4) @(negedge clk);
      chk_on = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
